// File: rtl/orgexp_pkg.sv
// Shared types and default widths for the orgexp video RAM arbitration path.
`timescale 1ns/1ps
package orgexp_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;

    // Owner of a command in flight through the memory pipeline.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_CPU  = 2'd2
    } tag_e;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_BUSY = 2'd1,
        C_ACK  = 2'd2
    } cpu_state_e;

endpackage

// File: rtl/vram_arb_pipe.sv
// Delays the owner tag of each granted VRAM command and steers the returned
// read word to the VGA or CPU response registers three cycles after the grant.
`timescale 1ns/1ps
module vram_arb_pipe
    import orgexp_pkg::*;
#(
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  tag_e              tag_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] vga_data_o,
    output logic              vga_valid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o
);

    localparam int STAGES = 3;

    tag_e tag_d [STAGES];
    tag_e tag_q [STAGES];
    logic we_d  [STAGES-1];
    logic we_q  [STAGES-1];

    logic [DATA_W-1:0] vga_data_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    assign tag_d[0] = tag_i;
    assign we_d[0]  = we_i;

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_tag_link
        assign tag_d[gi] = tag_q[gi-1];
    end

    for (genvar gi = 1; gi < STAGES - 1; gi++) begin : g_we_link
        assign we_d[gi] = we_q[gi-1];
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_tag_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tag_q[gi] <= TAG_NONE;
            end else begin
                tag_q[gi] <= tag_d[gi];
            end
        end
    end

    for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_we_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                we_q[gi] <= 1'b0;
            end else begin
                we_q[gi] <= we_d[gi];
            end
        end
    end

    // Stage 2 sees the RAM output; a CPU write leaves cpu_rdata untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            if (tag_q[1] == TAG_VGA) begin
                vga_data_q <= mem_rdata_i;
            end
            if ((tag_q[1] == TAG_CPU) && !we_q[1]) begin
                cpu_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign vga_data_o  = vga_data_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign vga_valid_o = (tag_q[STAGES-1] == TAG_VGA);
    assign cpu_ack_o   = (tag_q[STAGES-1] == TAG_CPU);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA fetches have priority, the CPU is forced
// through after STARVE_LIMIT consecutive losses. Fixed 3-cycle latency.
`timescale 1ns/1ps
module vram_arbiter
    import orgexp_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic              vga_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    cpu_state_e        state_q, state_d;
    logic              busy_cnt_q, busy_cnt_d;
    logic [7:0]        starve_q, starve_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              miss_q, miss_d;
    tag_e              tag_d;

    logic cpu_pend;
    logic cpu_force;
    logic cpu_gnt;
    logic vga_gnt;

    always_comb begin
        cpu_pend  = (state_q == C_IDLE) && cpu_req;
        cpu_force = (starve_q == STARVE_MAX);
        cpu_gnt   = cpu_pend && (!vga_req || cpu_force);
        vga_gnt   = vga_req && !cpu_gnt;
    end

    always_comb begin
        starve_d = 8'd0;
        if (cpu_pend && !cpu_gnt) begin
            starve_d = (starve_q < STARVE_MAX) ? starve_q + 8'd1 : starve_q;
        end
    end

    // Address and write data hold their last value on idle cycles.
    always_comb begin
        mem_en_d    = vga_gnt || cpu_gnt;
        mem_we_d    = cpu_gnt && cpu_we;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag_d       = TAG_NONE;
        miss_d      = vga_req && cpu_gnt;
        if (cpu_gnt) begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            tag_d       = TAG_CPU;
        end else if (vga_gnt) begin
            mem_addr_d  = vga_addr;
            tag_d       = TAG_VGA;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        case (state_q)
            C_IDLE: begin
                if (cpu_gnt) begin
                    state_d    = C_BUSY;
                    busy_cnt_d = 1'b0;
                end
            end
            C_BUSY: begin
                if (busy_cnt_q) begin
                    state_d = C_ACK;
                end else begin
                    busy_cnt_d = 1'b1;
                end
            end
            C_ACK:   state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= C_IDLE;
            busy_cnt_q  <= 1'b0;
            starve_q    <= 8'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            miss_q      <= miss_d;
        end
    end

    vram_arb_pipe #(
        .DATA_W (DATA_W)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .tag_i       (tag_d),
        .we_i        (mem_we_d),
        .mem_rdata_i (mem_rdata),
        .vga_data_o  (vga_data),
        .vga_valid_o (vga_valid),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ack_o   (cpu_ack)
    );

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign vga_miss  = miss_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: single-transaction vector table plus
// hand-written burst, contention, starvation and reset sequences.
`timescale 1ns/1ps
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          vga_valid;
    logic          vga_miss;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram [1<<AW];

    int n_pass  = 0;
    int n_total = 0;

    vram_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .vga_valid (vga_valid),
        .vga_miss  (vga_miss),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port RAM, read data valid one cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic          is_cpu;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One isolated access: request at T, command at T+1, response at T+3.
    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("vec%0d", idx);
        if (v.is_cpu) begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end else begin
            vga_req = 1'b1; vga_addr = v.addr;
        end
        step();                                        // T+1
        vga_req = 1'b0;
        chk({p, "_mem_en"},   32'(mem_en), 32'h1);
        chk({p, "_mem_we"},   32'(mem_we), 32'(v.we));
        chk({p, "_mem_addr"}, 32'(mem_addr), 32'(v.addr));
        if (v.we) chk({p, "_mem_wdata"}, 32'(mem_wdata), 32'(v.wdata));
        step();                                        // T+2
        chk({p, "_early_rsp"}, 32'(vga_valid | cpu_ack), 32'h0);
        step();                                        // T+3
        if (v.is_cpu) begin
            chk({p, "_cpu_ack"},   32'(cpu_ack), 32'h1);
            chk({p, "_cpu_rdata"}, 32'(cpu_rdata), 32'(v.exp_data));
            chk({p, "_vga_valid"}, 32'(vga_valid), 32'h0);
        end else begin
            chk({p, "_vga_valid"}, 32'(vga_valid), 32'h1);
            chk({p, "_vga_data"},  32'(vga_data), 32'(v.exp_data));
            chk({p, "_cpu_ack"},   32'(cpu_ack), 32'h0);
        end
        step();                                        // T+4
        cpu_req = 1'b0;
        chk({p, "_single_pulse"}, 32'(vga_valid | cpu_ack), 32'h0);
        $display("txn %s %s we=%0d addr=0x%04h expect=0x%02h", p,
                 v.is_cpu ? "cpu" : "vga", v.we, v.addr, v.exp_data);
        step();
    endtask

    initial begin
        rst = 1'b1;
        vga_req = 1'b0; vga_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_rdata = '0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
        for (int i = 0; i < 8; i++)  ram[i] = 8'(8'h30 + i);
        for (int i = 0; i < 32; i++) ram[8'h40 + i] = 8'(8'h80 + i);
        ram[13'h0010] = 8'hA5;

        vecs[0] = '{1'b1, 1'b0, 13'h0010, 8'h00, 8'hA5};
        vecs[1] = '{1'b0, 1'b0, 13'h0003, 8'h00, 8'h33};
        vecs[2] = '{1'b1, 1'b1, 13'h0120, 8'h77, 8'hA5};
        vecs[3] = '{1'b1, 1'b0, 13'h0120, 8'h00, 8'h77};
        vecs[4] = '{1'b0, 1'b0, 13'h0120, 8'h00, 8'h77};
        vecs[5] = '{1'b1, 1'b1, 13'h1FFF, 8'hFF, 8'h77};
        vecs[6] = '{1'b0, 1'b0, 13'h1FFF, 8'h00, 8'hFF};
        vecs[7] = '{1'b1, 1'b0, 13'h0000, 8'h00, 8'h30};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en",    32'(mem_en), 32'h0);
        chk("rst_mem_we",    32'(mem_we), 32'h0);
        chk("rst_mem_addr",  32'(mem_addr), 32'h0);
        chk("rst_cpu_ack",   32'(cpu_ack), 32'h0);
        chk("rst_vga_valid", 32'(vga_valid), 32'h0);
        chk("rst_vga_miss",  32'(vga_miss), 32'h0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_starve",    32'(dut.starve_q), 32'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // VGA burst: 8 back-to-back fetches of addresses 0..7.
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("burst_c%0d_mem_en", c), 32'(mem_en), 32'(c >= 1 && c <= 8));
            chk($sformatf("burst_c%0d_valid", c), 32'(vga_valid), 32'(c >= 3 && c <= 10));
            if (c >= 3 && c <= 10)
                chk($sformatf("burst_c%0d_data", c), 32'(vga_data), 32'(8'h30 + c - 3));
            vga_req  = (c < 8);
            vga_addr = 13'(c);
            step();
        end
        $display("txn burst vga addr 0..7");

        // Simultaneous requests with starve = 0: VGA first, CPU next cycle.
        for (int c = 0; c < 7; c++) begin
            if (c == 1) begin
                chk("sim_c1_addr", 32'(mem_addr), 32'h5);
                chk("sim_c1_we",   32'(mem_we), 32'h0);
            end
            if (c == 2) begin
                chk("sim_c2_en",   32'(mem_en), 32'h1);
                chk("sim_c2_addr", 32'(mem_addr), 32'h10);
            end
            chk($sformatf("sim_c%0d_valid", c), 32'(vga_valid), 32'(c == 3));
            chk($sformatf("sim_c%0d_ack", c), 32'(cpu_ack), 32'(c == 4));
            if (c == 3) chk("sim_vga_data", 32'(vga_data), 32'h35);
            if (c == 4) chk("sim_cpu_rdata", 32'(cpu_rdata), 32'hA5);
            vga_req  = (c == 0);
            vga_addr = 13'h0005;
            cpu_req  = (c <= 4);
            cpu_we   = 1'b0;
            cpu_addr = 13'h0010;
            step();
        end
        $display("txn simultaneous vga 0x0005 / cpu rd 0x0010");

        // Write then read of the same word with cpu_req held throughout.
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("wr_c%0d_mem_en", c), 32'(mem_en), 32'(c == 1 || c == 5));
            chk($sformatf("wr_c%0d_ack", c), 32'(cpu_ack), 32'(c == 3 || c == 7));
            if (c == 1) chk("wr_mem_we", 32'(mem_we), 32'h1);
            if (c == 5) chk("rd_mem_we", 32'(mem_we), 32'h0);
            if (c == 3) chk("wr_keeps_rdata", 32'(cpu_rdata), 32'hA5);
            if (c == 7) chk("rd_after_wr", 32'(cpu_rdata), 32'h3C);
            cpu_req   = (c < 8);
            cpu_we    = (c < 4);
            cpu_addr  = 13'h0100;
            cpu_wdata = 8'h3C;
            step();
        end
        $display("txn cpu wr 0x0100=0x3c then rd");

        // Starvation: VGA every cycle, CPU forced through at cycle 15.
        for (int c = 0; c < 25; c++) begin
            chk($sformatf("stv_c%0d_starve", c), 32'(dut.starve_q), (c <= 15) ? 32'(c) : 32'h0);
            chk($sformatf("stv_c%0d_mem_en", c), 32'(mem_en), 32'(c >= 1 && c <= 22));
            chk($sformatf("stv_c%0d_miss", c), 32'(vga_miss), 32'(c == 16));
            chk($sformatf("stv_c%0d_ack", c), 32'(cpu_ack), 32'(c == 18));
            chk($sformatf("stv_c%0d_valid", c), 32'(vga_valid),
                32'(c >= 3 && c <= 24 && c != 18));
            if (c >= 3 && c != 18)
                chk($sformatf("stv_c%0d_data", c), 32'(vga_data), 32'(8'h80 + c - 3));
            if (c == 16) chk("stv_cpu_addr", 32'(mem_addr), 32'h10);
            if (c == 18) chk("stv_cpu_rdata", 32'(cpu_rdata), 32'hA5);
            vga_req  = (c <= 21);
            vga_addr = 13'(8'h40 + c);
            cpu_req  = (c <= 18);
            cpu_we   = 1'b0;
            cpu_addr = 13'h0010;
            step();
        end
        $display("txn starvation cpu rd 0x0010 under continuous vga");

        // Reset two cycles into a CPU read.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0120;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_cpu_ack",   32'(cpu_ack), 32'h0);
        chk("mid_rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        chk("mid_rst_vga_data",  32'(vga_data), 32'h0);
        chk("mid_rst_mem_en",    32'(mem_en), 32'h0);
        chk("mid_rst_mem_addr",  32'(mem_addr), 32'h0);
        chk("mid_rst_vga_valid", 32'(vga_valid), 32'h0);
        cpu_req = 1'b0;
        step();
        chk("mid_rst_no_ack", 32'(cpu_ack), 32'h0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("post_rst_c%0d_ack", c), 32'(cpu_ack), 32'h0);
            chk($sformatf("post_rst_c%0d_en", c), 32'(mem_en), 32'h0);
        end
        $display("txn reset during cpu rd 0x0120");
        run_vec(vecs[0], 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates the single port of the shared video RAM between the VGA scan-out fetcher and the CPU data bus in the orgexp top level. Each cycle it grants at most one access. VGA has fixed priority, bounded by a CPU starvation limit. All memory commands and returned data are registered, giving a fixed three-cycle request-to-response latency for both requesters.

## Interface
- ADDR_W, 13, VRAM word-address width
- DATA_W, 8, VRAM word width
- STARVE_LIMIT, 15, consecutive denied CPU cycles before the CPU is forced through (1..255)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- vga_req  in  1  fetch request, single-cycle, may assert every cycle
- vga_addr  in  ADDR_W  fetch address, sampled with vga_req
- vga_data  out  DATA_W  fetched word, valid with vga_valid
- vga_valid  out  1  one-cycle response strobe
- vga_miss  out  1  one-cycle strobe: a VGA request was dropped
- cpu_req  in  1  level request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_W  stable while cpu_req is high
- cpu_wdata  in  DATA_W  stable while cpu_req is high
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion strobe, for reads and writes
- mem_en, mem_we  out  1  RAM port enable / write enable
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en

## Operation
- CPU FSM has three states:
  - C_IDLE: leaves on grant -> C_BUSY.
  - C_BUSY: holds for 2 cycles -> C_ACK.
  - C_ACK: asserts cpu_ack, lasts 1 cycle -> C_IDLE.
  - cpu_req is considered only in C_IDLE. A still-high cpu_req in the cycle after C_ACK is a new request.
- Grant decision, combinational from cycle T inputs:
  - If vga_req and CPU pending (C_IDLE and cpu_req): VGA wins, unless starve == STARVE_LIMIT. In that case the CPU wins and the VGA request is dropped.
  - Only one requester: that requester wins.
- Starve counter, 8 bits:
  - Increments each cycle the CPU is pending and loses.
  - Clears on a CPU grant or when the CPU is not pending.
  - Saturates at STARVE_LIMIT.
- A tag (NONE/VGA/CPU) travels with each granted command through a 3-stage delay. At stage 3, mem_rdata (captured at T+2) is routed to vga_data or cpu_rdata.
- For CPU writes, cpu_rdata keeps its previous value.

## Timing
- T: request sampled.
- T+1: mem_en/mem_we/mem_addr/mem_wdata driven from registers; vga_miss pulses here if the request was dropped.
- T+2: mem_rdata captured.
- T+3: vga_valid or cpu_ack asserted, with data.
- Fixed latency of 3 for both requesters. VGA throughput is 1/cycle; CPU throughput is at most 1 access per 4 cycles.
- Reset values: every output is 0, FSM is C_IDLE, starve is 0, all tags are NONE.
- Reset mid-operation: all in-flight accesses are discarded with no ack/valid. A write already presented on mem_* may or may not have completed; software re-issues it.
- Idle cycles drive mem_en = 0 and mem_we = 0; mem_addr and mem_wdata hold their previous values.

## Structure
- orgexp_pkg:
  - tag enum: TAG_NONE, TAG_VGA, TAG_CPU
  - CPU state enum: C_IDLE, C_BUSY, C_ACK
  - default widths VRAM_ADDR_W and VRAM_DATA_W
- Sub-module vram_arb_pipe: a 3-stage tag delay plus the rdata capture/steer register, instantiated once.
- Grant logic, starve counter and FSM live in vram_arbiter.

## Test plan
- CPU read alone: addr 0x0010 holds 0xA5; cpu_req at T -> mem_en at T+1, cpu_ack with cpu_rdata = 0xA5 at T+3, single pulse.
- VGA burst of 8 consecutive requests, addr 0..7 -> vga_valid on 8 consecutive cycles starting T+3, with data in address order.
- CPU write 0x3C to 0x0100, then CPU read of 0x0100 -> first ack at T+3, second request granted at T+4, read returns 0x3C at T+7.
- Continuous vga_req with cpu_req held -> CPU granted after exactly STARVE_LIMIT (15) denied cycles. vga_miss pulses once, one vga_valid is missing, and the starve counter returns to 0.
- Simultaneous vga_req and cpu_req with starve = 0 -> VGA granted, CPU granted the next cycle if vga_req is low.
- rst asserted at T+2 of a CPU read -> outputs 0 immediately, no cpu_ack, and a new request after reset completes normally.
